// File: rtl/encoder_16to4_seq_pkg.sv
// Shared constants and FSM state type for the 16-to-4 sequential encoder
// (and its 4-to-16 decoder counterpart).
package encoder_16to4_seq_pkg;

  localparam int ENC_N = 16;
  localparam int ENC_W = 4;
  localparam bit ENC_LSB_FIRST = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } enc_state_e;

endpackage

// File: rtl/encoder_16to4_seq_prio_find.sv
// Combinational priority search over a request vector: selected index,
// any-set and at-most-one-set, with the scan direction chosen at run time.
module encoder_16to4_seq_prio_find
  import encoder_16to4_seq_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic [N-1:0] i_vec,
  input  logic         i_lsb_first,
  output logic [W-1:0] o_idx,
  output logic         o_any,
  output logic         o_le_one
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Last match in scan order wins, so scan opposite to the priority direction
  always_comb begin
    o_idx = {W{1'b0}};
    if (i_lsb_first) begin
      for (int i = N - 1; i >= 0; i--) begin
        o_idx = i_vec[i] ? W'(i) : o_idx;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        o_idx = i_vec[i] ? W'(i) : o_idx;
      end
    end
  end

  assign o_any = |i_vec;
  // Clearing the lowest set bit leaves zero only for popcount 0 or 1
  assign o_le_one = ((i_vec & (i_vec - ONE)) == {N{1'b0}});

endmodule

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 encoder: accepts a request word and drains the index of
// every set bit, one per handshake beat, in priority order.
module encoder_16to4_seq
  import encoder_16to4_seq_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W,
  parameter bit LSB_FIRST = ENC_LSB_FIRST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
  output logic         out_onehot
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  enc_state_e   r_state;
  logic [N-1:0] r_pending;
  logic         r_none;
  logic         r_onehot;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_out_idx;
  logic         r_out_last;

  enc_state_e   w_state_nxt;
  logic [N-1:0] w_pending_nxt;
  logic         w_none_nxt;
  logic         w_onehot_nxt;
  logic [N-1:0] w_clr_mask;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_le_one;

  // Search runs on next-state pending so every output can be registered
  encoder_16to4_seq_prio_find #(
    .N (N),
    .W (W)
  ) u_prio_find (
    .i_vec       (w_pending_nxt),
    .i_lsb_first (LSB_FIRST),
    .o_idx       (w_idx),
    .o_any       (w_any),
    .o_le_one    (w_le_one)
  );

  assign w_clr_mask = ONE << r_out_idx;

  // Next state and pending word
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt   = ST_DRAIN;
          w_pending_nxt = in_word;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = r_pending;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_pending_nxt = r_pending & ~w_clr_mask;
          if (r_out_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_state_nxt   = ST_DRAIN;
          w_pending_nxt = r_pending;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = {N{1'b0}};
      end
    endcase
  end

  // Word flags: captured on accept, held across beats, cleared after the last beat
  always_comb begin
    w_none_nxt   = r_none;
    w_onehot_nxt = r_onehot;
    if ((r_state == ST_IDLE) && in_valid) begin
      w_none_nxt   = ~w_any;
      w_onehot_nxt = w_any & w_le_one;
    end else if ((r_state == ST_DRAIN) && out_ready && r_out_last) begin
      w_none_nxt   = 1'b0;
      w_onehot_nxt = 1'b0;
    end else begin
      w_none_nxt   = r_none;
      w_onehot_nxt = r_onehot;
    end
  end

  // State, pending word, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= {N{1'b0}};
      r_none      <= 1'b0;
      r_onehot    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_idx   <= {W{1'b0}};
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_none      <= w_none_nxt;
      r_onehot    <= w_onehot_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DRAIN);
      r_out_idx   <= (w_state_nxt == ST_DRAIN) ? w_idx : {W{1'b0}};
      r_out_last  <= (w_state_nxt == ST_DRAIN) ? w_le_one : 1'b0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;
  assign out_none   = r_none;
  assign out_onehot = r_onehot;

endmodule

// File: doc/encoder_16to4_seq.md
Name: encoder_16to4_seq

Overview:
- Reverse direction of the team's 4-to-16 one-hot decoder: takes a 16-bit request word and emits the 4-bit index of every set bit, one index per handshake beat, in priority order.
- A one-hot word yields exactly one beat, recovering the decoder's select value. Multi-hot words are drained serially.
- Sits between interrupt/request aggregation logic and any consumer that takes one encoded index at a time.

Parameters:
- N, 16, request word width; must be a power of two ≥ 2.
- W, 4, index width = log2(N).
- LSB_FIRST, 1, 1 = lowest set index emitted first; 0 = highest set index first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request word available.
- in_ready  output  1  block can accept a word.
- in_word  input  N  request vector; bit k set = request k.
- out_valid  output  1  index beat available.
- out_ready  input  1  consumer accepts the beat.
- out_idx  output  W  encoded index of the current bit.
- out_last  output  1  final beat of the current word.
- out_none  output  1  word was all-zero; out_idx = 0 on this beat.
- out_onehot  output  1  word had exactly one bit set; constant across all beats of a word.

Behaviour:
- State machine: IDLE, DRAIN.
- Reset, asynchronous on rst_n low:
  - state = IDLE; pending register = 0.
  - in_ready = 1; out_valid = 0.
  - out_idx = 0; out_last = 0; out_none = 0; out_onehot = 0.
- IDLE:
  - in_ready = 1; out_valid = 0.
  - Accept occurs when in_valid && in_ready at a clock edge. On accept: pending <= in_word; none_flag <= (in_word == 0); onehot_flag <= (popcount == 1); go to DRAIN.
- DRAIN:
  - in_ready = 0; out_valid = 1.
  - out_idx = the selected set bit of pending: lowest if LSB_FIRST = 1, else highest. 0 when pending = 0.
  - out_last = 1 when pending has ≤ 1 bit set.
  - out_none = none_flag; out_onehot = onehot_flag.
- Beat transfer, DRAIN with out_ready = 1:
  - Clear bit out_idx in pending.
  - If out_last: go to IDLE and clear the flags.
  - Otherwise stay in DRAIN.
- Stall: out_ready = 0 holds out_idx, out_last, out_none and out_onehot stable. out_valid must not drop until the beat transfers.
- Latency: word accepted at edge T gives first out_valid at T+1. A word with k set bits (k ≥ 1) occupies k beats; an all-zero word occupies 1 beat.
- Throughput: in_ready is 0 throughout DRAIN, so the next word is accepted at the edge after the last beat transfers. This gives a minimum 1-cycle IDLE bubble between words.
- Outputs are derived only from registered state (pending, flags, state). There is no combinational path from in_* to out_*, and none from out_ready to in_ready.
- in_word is ignored while in_ready = 0.
- Reset mid-DRAIN discards the pending word immediately. No partial beat remains.
- Width rules: the index search covers exactly N bits; out_idx is W bits with no truncation. The popcount used for onehot_flag needs only a 0 / 1 / ≥2 saturating result.

Decomposition:
- Shared package, also usable by the decoder: N and W constants, LSB_FIRST default, and the state enum {IDLE, DRAIN}.
- One natural sub-module, prio_find, is purely combinational:
  - Inputs: pending vector and a direction flag.
  - Outputs: found index, any-set, and at-most-one-set.
  - The top instantiates it once and holds the FSM, pending register and flags.

Test Plan:
- Reset while in_word = 16'hFFFF and in_valid = 1 is driven → all outputs 0, in_ready = 1. Release rst_n → accept on the next edge.
- Send 16'h0020 with out_ready = 1 → one beat at T+1: idx = 5, last = 1, onehot = 1, none = 0. in_ready is 1 again at T+2.
- Send 16'h8011 with LSB_FIRST = 1 and out_ready = 1 → beats idx 0, 4, 15; last only on 15; onehot = 0. With LSB_FIRST = 0 the order is 15, 4, 0.
- Send 16'h0000 → single beat: idx = 0, none = 1, last = 1, onehot = 0.
- Send 16'h0006 and hold out_ready = 0 for 5 cycles → idx = 1 stays stable with valid held. Release → idx 1, then 2 (last). in_valid held high during DRAIN causes no accept.
- Send 16'hFFFF, then pulse rst_n low after the 3rd beat → outputs clear asynchronously. A following word 16'h0100 yields a single beat with idx = 8.
